// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one binary<->Gray conversion engine among NREQ requesters.
// Bin->Gray takes one conversion cycle; Gray->bin is resolved bit-serially, MSB first.
module gray_conv_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_mode,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDW-1:0]          out_id,
  output logic                    out_mode,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_last;
  logic [IDW-1:0]   id_r;
  logic             mode_r;
  logic [WIDTH-1:0] g_r;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;

  logic [IDW-1:0]   grant;
  logic             grant_ok;
  logic [IDW-1:0]   scan_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(rr_last) + k) % NREQ);
      if (!grant_ok && req_valid[scan_idx]) begin
        grant_ok = 1'b1;
        grant    = scan_idx;
      end else begin
        grant_ok = grant_ok;
      end
    end
  end

  // Select the granted requester's word and mode.
  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mode = req_mode[i];
      end else begin
        sel_data = sel_data;
      end
    end
  end

  assign req_ready = (state == IDLE && grant_ok && !rst)
                   ? ({{(NREQ-1){1'b0}}, 1'b1} << grant) : '0;
  assign busy      = (state != IDLE);

  // Scheduler FSM, conversion datapath and registered result port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= IDW'(NREQ - 1);
      id_r      <= '0;
      mode_r    <= 1'b0;
      g_r       <= '0;
      work      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            g_r     <= sel_data;
            mode_r  <= sel_mode;
            id_r    <= grant;
            rr_last <= grant;
            state   <= CONV;
            if (sel_mode) begin
              work <= {sel_data[WIDTH-1], {(WIDTH-1){1'b0}}};
              cnt  <= CW'(WIDTH - 2);
            end else begin
              work <= '0;
              cnt  <= '0;
            end
          end
        end
        CONV: begin
          if (!mode_r) begin
            work  <= g_r ^ (g_r >> 1);
            state <= DONE;
          end else begin
            // Each binary bit is the next-higher binary bit XOR this Gray bit.
            work[cnt] <= work[cnt + CW'(1)] ^ g_r[cnt];
            if (cnt == '0) begin
              state <= DONE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= work;
            out_id    <= id_r;
            out_mode  <= mode_r;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_sched.sv
// Directed bench for gray_conv_sched: single-requester vector table, fairness,
// output hold under backpressure, reset abort and an exhaustive round trip.
module tb_gray_conv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_mode, req_ready;
  logic [15:0] req_data;
  logic        out_valid, out_ready, out_mode, busy;
  logic [3:0]  out_data;
  logic [1:0]  out_id;

  int errors = 0;
  int checks = 0;

  gray_conv_sched #(.WIDTH(4), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_mode(out_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       mode;
    logic [3:0] data;
    logic [3:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_req(input int id, input logic mode, input logic [3:0] data,
                         input logic [3:0] exp, input int lat);
    bit ok;
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = 4'b0001 << id;
    req_mode  = mode ? (4'b0001 << id) : 4'b0000;
    req_data  = {12'h000, data} << (4 * id);
    wait_ready(ok);
    chk("ready_seen", 32'(ok), 32'd1);
    chk("req_ready", 32'(req_ready), 32'(4'b0001 << id));
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    req_mode  = 4'b1111;
    req_data  = 16'hFFFF;
    chk("busy_conv", 32'(busy), 32'd1);
    wait_valid(n);
    chk("latency", 32'(n), 32'(lat));
    chk("out_data", 32'(out_data), 32'(exp));
    chk("out_id", 32'(out_id), 32'(id));
    chk("out_mode", 32'(out_mode), 32'(mode));
    @(posedge clk);
    #1;
    chk("released", 32'(out_valid), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    bit         ok;
    int         n;
    logic [3:0] fexp[4];
    int         flat[4];
    logic [3:0] g;
    logic [3:0] b;

    vecs[0] = '{2, 1'b0, 4'b1011, 4'b1110, 2};
    vecs[1] = '{1, 1'b1, 4'b1110, 4'b1011, 4};
    vecs[2] = '{1, 1'b1, 4'b1000, 4'b1111, 4};
    vecs[3] = '{1, 1'b1, 4'b0000, 4'b0000, 4};
    vecs[4] = '{0, 1'b0, 4'b0000, 4'b0000, 2};
    vecs[5] = '{3, 1'b1, 4'b0001, 4'b0001, 4};
    vecs[6] = '{3, 1'b0, 4'b1111, 4'b1000, 2};

    rst = 1'b1;
    req_valid = 4'b0000;
    req_mode  = 4'b0000;
    req_data  = 16'h0000;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++)
      run_req(vecs[v].id, vecs[v].mode, vecs[v].data, vecs[v].exp, vecs[v].lat);

    // Fairness: all four requesters held valid, alternating modes.
    do_reset();
    fexp = '{4'b0010, 4'b0100, 4'b1101, 4'b1010};
    flat = '{2, 4, 2, 4};
    out_ready = 1'b1;
    req_valid = 4'b1111;
    req_mode  = 4'b1010;
    req_data  = {4'b1111, 4'b1001, 4'b0110, 4'b0011};
    for (int k = 0; k < 6; k++) begin
      wait_ready(ok);
      chk("rr_seen", 32'(ok), 32'd1);
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      @(posedge clk);
      #1;
      wait_valid(n);
      chk("rr_latency", 32'(n), 32'(flat[k % 4]));
      chk("rr_out_id", 32'(out_id), 32'(k % 4));
      chk("rr_out_data", 32'(out_data), 32'(fexp[k % 4]));
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0000;

    // Backpressure: result held five cycles with out_ready low.
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_mode  = 4'b0000;
    req_data  = 16'h0006;
    wait_ready(ok);
    chk("hold_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    wait_valid(n);
    chk("hold_latency", 32'(n), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(4'b0101));
      chk("hold_id", 32'(out_id), 32'd0);
      chk("hold_ready0", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_idle", 32'(busy), 32'd0);
    chk("hold_released", 32'(out_valid), 32'd0);
    chk("hold_next_grant", 32'(req_ready), 32'(4'b0010));
    req_valid = 4'b0000;

    // Reset in the middle of a Gray->bin conversion.
    do_reset();
    req_valid = 4'b0100;
    req_mode  = 4'b0100;
    req_data  = 16'h0E00;
    wait_ready(ok);
    chk("abort_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1001;
    req_mode  = 4'b0000;
    req_data  = 16'h5001;
    wait_ready(ok);
    chk("abort_next_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_valid(n);
    chk("abort_next_data", 32'(out_data), 32'(4'b0001));
    chk("abort_next_id", 32'(out_id), 32'd0);
    @(posedge clk);
    #1;

    // Exhaustive round trip: bin->gray then gray->bin restores the word.
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      g = b ^ (b >> 1);
      run_req(i % 4, 1'b0, b, g, 2);
      run_req((i + 1) % 4, 1'b1, g, b, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
